// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS controller: steps the shared ALU / memory / register-file
// datapath through fetch, decode, execute, memory and write-back states.
// Memory states wait on Mem_ready; a stalled access is abandoned after
// MEM_TIMEOUT idle cycles (0 disables the abort). Retired instructions are
// counted modulo 2^COUNT_W.
// Optional feature: define MC_CTRL_ADDI_EN to execute addi (opcode 001000);
// otherwise that opcode traps as illegal.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_FETCH     | read instruction at PC, PC+4 and IR load when memory is ready
// S_DECODE    | branch target precompute, dispatch on Opcode
// S_R_EXEC    | R-type ALU operation rs op rt
// S_R_WB      | write ALUOut to rd, retire
// S_MEM_ADDR  | effective address rs + sign-extended immediate
// S_MEM_READ  | load data read at ALUOut, wait for memory
// S_MEM_WB    | write MDR to rt, retire
// S_MEM_WRITE | store rt at ALUOut, wait for memory, retire
// S_BRANCH    | compare rs - rt, conditional PC load, retire
// S_JUMP      | PC load from jump target, retire
// S_TRAP      | unsupported opcode, flag and return to fetch
// S_ADDI_EXEC | addi: rs + sign-extended immediate
// S_ADDI_WB   | addi: write ALUOut to rt, retire
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Opcode,
  input  logic               Mem_ready,
  output logic               PC_write,
  output logic               PC_write_cond,
  output logic               I_or_D,
  output logic               Mem_read,
  output logic               Mem_write,
  output logic               IR_write,
  output logic               Mem_to_reg,
  output logic               Reg_dst,
  output logic               Reg_write,
  output logic               Alu_src_a,
  output logic [1:0]         Alu_src_b,
  output logic [1:0]         Alu_op,
  output logic [1:0]         Pc_source,
  output logic               Instr_done,
  output logic               Illegal_op,
  output logic               Mem_timeout,
  output logic [COUNT_W-1:0] Instr_count
);

`ifdef MC_CTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Wait timer is a down-counter loaded with MEM_TIMEOUT; terminal count 0
  // reached while still waiting means the access has had its full budget.
  localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT);
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_R_EXEC,
    S_R_WB,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_JUMP,
    S_TRAP,
    S_ADDI_EXEC,
    S_ADDI_WB
  } state_t;

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 mem_wait;
  logic                 timeout;

  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE)) && !Mem_ready;
  assign timeout  = TIMEOUT_EN && mem_wait && (wait_q == '0);
  // Any cycle that is not a continuing wait (ready, new state, abort) reloads.
  assign wait_d   = (TIMEOUT_EN && mem_wait && !timeout) ? (wait_q - WAIT_W'(1)) : WAIT_LOAD;
  assign cnt_d    = cnt_q + COUNT_W'(Instr_done);
  // Reset forces every output low, including the visible count.
  assign Instr_count = rst ? '0 : cnt_q;

  // State, wait timer and retire counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= WAIT_LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Moore-style control decode (Mem_ready qualifies handshakes).
  always_comb begin
    state_d       = state_q;
    PC_write      = 1'b0;
    PC_write_cond = 1'b0;
    I_or_D        = 1'b0;
    Mem_read      = 1'b0;
    Mem_write     = 1'b0;
    IR_write      = 1'b0;
    Mem_to_reg    = 1'b0;
    Reg_dst       = 1'b0;
    Reg_write     = 1'b0;
    Alu_src_a     = 1'b0;
    Alu_src_b     = 2'b00;
    Alu_op        = 2'b00;
    Pc_source     = 2'b00;
    Instr_done    = 1'b0;
    Illegal_op    = 1'b0;
    Mem_timeout   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          Mem_read  = 1'b1;
          Alu_src_b = 2'b01;
          IR_write  = Mem_ready;
          PC_write  = Mem_ready;
          if (Mem_ready) begin
            state_d = S_DECODE;
          end else if (timeout) begin
            Mem_timeout = 1'b1;
            state_d     = S_FETCH;
          end
        end
        S_DECODE: begin
          Alu_src_b = 2'b11;
          case (Opcode)
            OP_RTYPE:      state_d = S_R_EXEC;
            OP_LW, OP_SW:  state_d = S_MEM_ADDR;
            OP_BEQ:        state_d = S_BRANCH;
            OP_J:          state_d = S_JUMP;
            OP_ADDI:       state_d = ADDI_EN ? S_ADDI_EXEC : S_TRAP;
            default:       state_d = S_TRAP;
          endcase
        end
        S_R_EXEC: begin
          Alu_src_a = 1'b1;
          Alu_op    = 2'b10;
          state_d   = S_R_WB;
        end
        S_R_WB: begin
          Reg_dst    = 1'b1;
          Reg_write  = 1'b1;
          Instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEM_ADDR: begin
          Alu_src_a = 1'b1;
          Alu_src_b = 2'b10;
          state_d   = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          Mem_read = 1'b1;
          I_or_D   = 1'b1;
          if (Mem_ready) begin
            state_d = S_MEM_WB;
          end else if (timeout) begin
            Mem_timeout = 1'b1;
            state_d     = S_FETCH;
          end
        end
        S_MEM_WB: begin
          Reg_write  = 1'b1;
          Mem_to_reg = 1'b1;
          Instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEM_WRITE: begin
          Mem_write = 1'b1;
          I_or_D    = 1'b1;
          if (Mem_ready) begin
            Instr_done = 1'b1;
            state_d    = S_FETCH;
          end else if (timeout) begin
            Mem_timeout = 1'b1;
            state_d     = S_FETCH;
          end
        end
        S_BRANCH: begin
          Alu_src_a     = 1'b1;
          Alu_op        = 2'b01;
          PC_write_cond = 1'b1;
          Pc_source     = 2'b01;
          Instr_done    = 1'b1;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          PC_write   = 1'b1;
          Pc_source  = 2'b10;
          Instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_TRAP: begin
          Illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
        S_ADDI_EXEC: begin
          Alu_src_a = 1'b1;
          Alu_src_b = 2'b10;
          state_d   = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          Reg_write  = 1'b1;
          Instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm. Expected per-cycle traces are generated
// from instruction-level rules (phase list per opcode, wait/timeout budget,
// retire count) into a table of {inputs, expected outputs} records, which
// is then applied cycle by cycle and compared.
module tb_multicycle_control_fsm;

  localparam int TO = 15;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

`ifdef MC_CTRL_ADDI_EN
  localparam bit ADDI_ON = 1'b1;
`else
  localparam bit ADDI_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  Opcode = '0;
  logic        Mem_ready = 1'b0;
  logic        PC_write, PC_write_cond, I_or_D, Mem_read, Mem_write, IR_write;
  logic        Mem_to_reg, Reg_dst, Reg_write, Alu_src_a;
  logic [1:0]  Alu_src_b, Alu_op, Pc_source;
  logic        Instr_done, Illegal_op, Mem_timeout;
  logic [15:0] Instr_count;
  logic [18:0] act;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(TO), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Mem_ready(Mem_ready),
    .PC_write(PC_write), .PC_write_cond(PC_write_cond), .I_or_D(I_or_D),
    .Mem_read(Mem_read), .Mem_write(Mem_write), .IR_write(IR_write),
    .Mem_to_reg(Mem_to_reg), .Reg_dst(Reg_dst), .Reg_write(Reg_write),
    .Alu_src_a(Alu_src_a), .Alu_src_b(Alu_src_b), .Alu_op(Alu_op),
    .Pc_source(Pc_source), .Instr_done(Instr_done), .Illegal_op(Illegal_op),
    .Mem_timeout(Mem_timeout), .Instr_count(Instr_count)
  );

  assign act = {PC_write, PC_write_cond, I_or_D, Mem_read, Mem_write, IR_write,
                Mem_to_reg, Reg_dst, Reg_write, Alu_src_a, Alu_src_b, Alu_op,
                Pc_source, Instr_done, Illegal_op, Mem_timeout};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [18:0] exp;
    logic [15:0] cnt;
    string       tag;
  } ent_t;

  ent_t        trace[$];
  logic [15:0] model_cnt = '0;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [18:0] mk(
    input logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa,
    input logic [1:0] asb, aop, psrc,
    input logic done, ill, tmo);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, done, ill, tmo};
  endfunction

  // Control word of a memory-phase cycle: kind 0 fetch, 1 load, 2 store.
  function automatic logic [18:0] mem_phase(input int kind, input logic rdy, input logic tmo);
    if (kind == 0)      return mk(rdy,0,0,1,0,rdy,0,0,0,0,2'b01,2'b00,2'b00,0,0,tmo);
    else if (kind == 1) return mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,tmo);
    else                return mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,rdy,0,tmo);
  endfunction

  task automatic push(input logic r, input logic [5:0] op, input logic rdy,
                      input logic [18:0] exp, input string tag);
    ent_t e;
    e.rst = r; e.op = op; e.rdy = rdy; e.exp = exp;
    e.cnt = r ? 16'h0 : model_cnt;
    e.tag = tag;
    trace.push_back(e);
  endtask

  task automatic push_rst(input string tag);
    push(1'b1, 6'($urandom), 1'($urandom), 19'h0, tag);
    model_cnt = '0;
  endtask

  // Plain cycle whose outputs do not depend on Mem_ready.
  task automatic push_plain(input logic [5:0] op, input logic [18:0] exp, input string tag);
    push(1'b0, op, 1'($urandom), exp, tag);
  endtask

  // Memory phase: 'waits' not-ready cycles, then ready; the (TO+1)th
  // not-ready cycle aborts instead.
  task automatic gen_mem(input int kind, input logic [5:0] op, input int waits, output bit ok);
    int n;
    n = (waits > TO) ? TO : waits;
    for (int i = 0; i < n; i++) push(1'b0, op, 1'b0, mem_phase(kind, 1'b0, 1'b0), "mem_wait");
    if (waits > TO) begin
      push(1'b0, op, 1'b0, mem_phase(kind, 1'b0, 1'b1), "mem_timeout");
      ok = 1'b0;
    end else begin
      push(1'b0, op, 1'b1, mem_phase(kind, 1'b1, 1'b0), "mem_ready");
      ok = 1'b1;
      if (kind == 2) model_cnt++;
    end
  endtask

  task automatic gen_instr(input logic [5:0] op, input int fw, input int mw);
    bit ok;
    gen_mem(0, op, fw, ok);
    if (!ok) return;
    push_plain(op, mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0), "decode");
    if (op == OP_R) begin
      push_plain(op, mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0), "r_exec");
      push_plain(op, mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0,0), "r_wb");
      model_cnt++;
    end else if (op == OP_LW || op == OP_SW) begin
      push_plain(op, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), "mem_addr");
      gen_mem((op == OP_LW) ? 1 : 2, op, mw, ok);
      if (ok && op == OP_LW) begin
        push_plain(op, mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0,0), "mem_wb");
        model_cnt++;
      end
    end else if (op == OP_BEQ) begin
      push_plain(op, mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,0), "branch");
      model_cnt++;
    end else if (op == OP_J) begin
      push_plain(op, mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0), "jump");
      model_cnt++;
    end else if (op == OP_ADDI && ADDI_ON) begin
      push_plain(op, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), "addi_exec");
      push_plain(op, mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0,0), "addi_wb");
      model_cnt++;
    end else begin
      push_plain(op, mk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,0), "trap");
    end
  endtask

  task automatic run_trace();
    foreach (trace[i]) begin
      @(posedge clk);
      #1;
      rst       = trace[i].rst;
      Opcode    = trace[i].op;
      Mem_ready = trace[i].rdy;
      @(negedge clk);
      checks++;
      if (act !== trace[i].exp) begin
        failures++;
        $display("FAIL ctrl[%s] entry %0d: got %b expected %b", trace[i].tag, i, act, trace[i].exp);
      end
      checks++;
      if (Instr_count !== trace[i].cnt) begin
        failures++;
        $display("FAIL count[%s] entry %0d: got %0d expected %0d", trace[i].tag, i, Instr_count, trace[i].cnt);
      end
    end
    trace.delete();
  endtask

  initial begin
    bit ok;
    logic [5:0] op;
    int fw, mw;

    // Directed: reset, each opcode, wait/timeout boundaries, mid-access reset.
    push_rst("reset0");
    push_rst("reset1");
    gen_instr(OP_R, 0, 0);
    gen_instr(OP_LW, 0, 3);
    gen_instr(OP_SW, 0, 0);
    gen_instr(OP_BEQ, 0, 0);
    gen_instr(OP_J, 0, 0);
    gen_instr(OP_BAD, 20, 0);
    gen_instr(OP_BAD, 4, 0);
    gen_instr(OP_R, TO, 0);
    gen_instr(OP_LW, 0, TO + 1);
    gen_instr(OP_SW, 2, TO + 1);
    gen_instr(OP_SW, 1, TO);
    gen_instr(OP_ADDI, 0, 0);
    gen_mem(0, OP_LW, 0, ok);
    push_plain(OP_LW, mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0), "decode");
    push_plain(OP_LW, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), "mem_addr");
    push(1'b1, OP_LW, 1'b0, 19'h0, "rst_in_mem_read");
    model_cnt = '0;
    gen_instr(OP_ADDI, 0, 0);
    gen_instr(OP_R, 0, 0);
    run_trace();

    // Randomized instruction stream.
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 7))
        0: op = OP_R;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_J;
        5: op = OP_ADDI;
        default: op = 6'($urandom);
      endcase
      fw = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 3);
      gen_instr(op, fw, mw);
      if ($urandom_range(0, 40) == 0) push_rst("rand_reset");
    end
    run_trace();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
